// File: rtl/deselect4_arbiter.sv
// deselect4_arbiter: round-robin sharing of one Deselect4 mux between two requesters with a registered, error-flagged output buffer
module deselect4_arbiter #(
  parameter int ERR_CNT_W = 8,
  parameter bit CHECK_ILLEGAL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [7:0]           a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [7:0]           b_data,
  output logic                 dsel_sel,
  output logic [7:0]           dsel_a,
  output logic [7:0]           dsel_b,
  input  logic [7:0]           dsel_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic                 out_src,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  logic can_acc, gnt_a, gnt_b, xfer, ptr, sel_q, y_err;
  assign dsel_a = a_data;
  assign dsel_b = b_data;
  assign can_acc = !rst && (!out_valid || out_ready);
  // ptr=0 prefers A on contention, ptr=1 prefers B
  assign gnt_a = can_acc && a_valid && (!b_valid || !ptr);
  assign gnt_b = can_acc && b_valid && (!a_valid || ptr);
  assign a_ready = gnt_a;
  assign b_ready = gnt_b;
  assign xfer = gnt_a || gnt_b;
  assign dsel_sel = rst ? 1'b0 : gnt_b ? 1'b1 : gnt_a ? 1'b0 : sel_q;
  assign y_err = CHECK_ILLEGAL && (dsel_y[7:6] == 2'b00 || dsel_y[5:4] == 2'b00 ||
                                   dsel_y[3:2] == 2'b00 || dsel_y[1:0] == 2'b00);
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 8'hFF;
      out_src   <= 1'b0;
      out_err   <= 1'b0;
      err_cnt   <= '0;
      ptr       <= 1'b0;
      sel_q     <= 1'b0;
    end else begin
      sel_q <= dsel_sel;
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= dsel_y;
        out_src   <= gnt_b;
        out_err   <= y_err;
        ptr       <= gnt_a;
        if (y_err && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_deselect4_arbiter.sv
// tb_deselect4_arbiter: scoreboard bench with an independent grant/pointer model and a behavioural Deselect4
module tb_deselect4_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, a_valid, b_valid, out_ready;
  logic [7:0] a_data, b_data, dsel_a, dsel_b, dsel_y, out_data, err_cnt;
  logic a_ready, b_ready, dsel_sel, out_valid, out_src, out_err;
  int n_chk = 0, n_fail = 0;
  typedef struct packed {logic src; logic err; logic [7:0] d;} exp_t;
  exp_t sb[$];
  logic m_ptr, m_valid, m_sel;
  int m_cnt;

  deselect4_arbiter dut (
    .clk(clk), .rst(rst), .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .dsel_sel(dsel_sel),
    .dsel_a(dsel_a), .dsel_b(dsel_b), .dsel_y(dsel_y), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_src(out_src), .out_err(out_err),
    .err_cnt(err_cnt)
  );

  assign dsel_y = dsel_sel ? dsel_b : dsel_a;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic ill(input logic [7:0] d);
    return d[7:6] == 2'b00 || d[5:4] == 2'b00 || d[3:2] == 2'b00 || d[1:0] == 2'b00;
  endfunction

  task automatic step();
    logic can, ga, gb, esel;
    exp_t e;
    #1;
    can = !rst && (!m_valid || out_ready);
    ga = can && a_valid && (!b_valid || !m_ptr);
    gb = can && b_valid && (!a_valid || m_ptr);
    esel = rst ? 1'b0 : gb ? 1'b1 : ga ? 1'b0 : m_sel;
    chk("a_ready", a_ready, ga);
    chk("b_ready", b_ready, gb);
    chk("dsel_sel", dsel_sel, esel);
    chk("dsel_a", dsel_a, a_data);
    chk("dsel_b", dsel_b, b_data);
    if (!rst && m_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_src", out_src, e.src);
        chk("out_err", out_err, e.err);
      end
    end
    if (ga) sb.push_back({1'b0, ill(a_data), a_data});
    if (gb) sb.push_back({1'b1, ill(b_data), b_data});
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 0; m_ptr = 0; m_sel = 0; m_cnt = 0;
      sb.delete();
    end else begin
      m_sel = esel;
      if (ga || gb) begin
        m_valid = 1;
        m_ptr = ga;
        if (ill(ga ? a_data : b_data) && m_cnt < 255) m_cnt++;
      end else if (m_valid && out_ready) m_valid = 0;
    end
    chk("out_valid", out_valid, m_valid);
    chk("err_cnt", err_cnt, m_cnt);
    @(negedge clk);
  endtask

  initial begin
    rst = 1; a_valid = 0; b_valid = 0; out_ready = 1; a_data = 8'h96; b_data = 8'h69;
    m_ptr = 0; m_valid = 0; m_sel = 0; m_cnt = 0;
    @(negedge clk);
    step();
    rst = 0;
    chk("rst_out_data", out_data, 8'hFF);
    chk("rst_out_src", out_src, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_out_valid", out_valid, 0);
    repeat (2) step();
    a_valid = 1;
    step();
    chk("a_alone_data", out_data, 8'h96);
    a_valid = 0;
    step();
    a_valid = 1; b_valid = 1;
    repeat (4) step();
    a_valid = 0;
    step();
    chk("bp_first_b", out_data, 8'h69);
    a_valid = 1; out_ready = 0;
    repeat (5) step();
    chk("bp_hold_data", out_data, 8'h69);
    out_ready = 1;
    step();
    chk("bp_release_src", out_src, 0);
    a_valid = 0; b_valid = 1; b_data = 8'h3C;
    step();
    chk("illegal_flag", out_err, 1);
    repeat (299) step();
    chk("err_cnt_sat", err_cnt, 8'hFF);
    b_data = 8'h69; a_valid = 1; out_ready = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt", err_cnt, 0);
    out_ready = 1;
    step();
    chk("post_rst_grant_a", out_src, 0);
    a_valid = 0; b_valid = 0;
    repeat (3) step();
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
